frame_stream_arbiter: RTL

//  Shares one unpacked tile stream between NUM_REQ producers, with frame-granular round-robin arbitration.
//  A frame is IN_Y rows x (IN_X/UNROLL_IN_X) beats of UNROLL_IN_X elements, the unit the row-cut datapath consumes.
//  The grant is locked for a whole frame, so row/column counters downstream never see interleaved producers.

---
 rtl/frame_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/frame_stream_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/frame_arb_pkg.sv
// Shared types and elaboration helpers for the frame stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_e;

    // Beats per frame row.
    function automatic int iter_x(input int in_x, input int unroll);
        return in_x / unroll;
    endfunction

    // Counter width for a count of n, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Picks the first asserted request at or after ptr, searching cyclically.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    // Cyclic scan starting at ptr; the first hit wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt_idx = '0;
        any_req = |req;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing one beat stream among NUM_REQ producers.
// Latency: 1-cycle arbitration bubble per frame; data_out_valid 1 cycle after input handshake.
// Backpressure: granted producer sees ready while the 2-entry output slice has room; others see 0.
module frame_stream_arbiter
    import frame_arb_pkg::*;
#(
    parameter  int IN_WIDTH    = 32,
    parameter  int IN_X        = 10,
    parameter  int IN_Y        = 2,
    parameter  int UNROLL_IN_X = 5,
    parameter  int NUM_REQ     = 4,
    localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] data_in [NUM_REQ][UNROLL_IN_X],
    input  logic [NUM_REQ-1:0]  data_in_valid,
    output logic [NUM_REQ-1:0]  data_in_ready,
    output logic [IN_WIDTH-1:0] data_out [UNROLL_IN_X],
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic [GID_W-1:0]    grant_id,
    output logic                busy,
    output logic                frame_done
);

    localparam int ITER_X = iter_x(IN_X, UNROLL_IN_X);
    localparam int X_W    = cnt_width(ITER_X);
    localparam int Y_W    = cnt_width(IN_Y);

    if (IN_X % UNROLL_IN_X != 0) begin : g_bad_unroll
        $error("IN_X must be a multiple of UNROLL_IN_X");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be at least 2");
    end

    arb_state_e         state;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   pick_idx;
    logic               any_req;
    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;

    logic [IN_WIDTH-1:0] slice_mem [2][UNROLL_IN_X];
    logic [1:0]          slice_cnt;
    logic                slice_wr_ptr;
    logic                slice_rd_ptr;
    logic                slice_can_accept;
    logic                in_fire;
    logic                out_fire;
    logic                last_col;
    logic                last_row;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (data_in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    // The slice only advertises room from its registered fill level, so ready never depends on data_out_ready.
    assign slice_can_accept = (slice_cnt != 2'd2);
    assign in_fire          = (state == STREAM) && slice_can_accept && data_in_valid[grant_id];
    assign out_fire         = data_out_valid && data_out_ready;
    assign data_out_valid   = (slice_cnt != 2'd0);
    assign last_col         = (x_cnt == X_W'(ITER_X - 1));
    assign last_row         = (y_cnt == Y_W'(IN_Y - 1));

    // Only the granted producer may see ready, and only while streaming.
    always_comb begin
        data_in_ready = '0;
        if (state == STREAM && slice_can_accept) begin
            data_in_ready[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM: grant held for a whole frame, pointer advances past the finished producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        if (last_col) begin
                            x_cnt <= '0;
                            if (last_row) begin
                                y_cnt      <= '0;
                                frame_done <= 1'b1;
                                rr_ptr     <= (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid slice bookkeeping: fill level and ring pointers, cleared by reset so a partial frame is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slice_cnt    <= 2'd0;
            slice_wr_ptr <= 1'b0;
            slice_rd_ptr <= 1'b0;
        end else begin
            if (in_fire) begin
                slice_wr_ptr <= ~slice_wr_ptr;
            end
            if (out_fire) begin
                slice_rd_ptr <= ~slice_rd_ptr;
            end
            case ({in_fire, out_fire})
                2'b10:   slice_cnt <= slice_cnt + 2'd1;
                2'b01:   slice_cnt <= slice_cnt - 2'd1;
                default: slice_cnt <= slice_cnt;
            endcase
        end
    end

    // Slice storage: data registers need no reset, validity lives in slice_cnt.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int e = 0; e < UNROLL_IN_X; e++) begin
                slice_mem[slice_wr_ptr][e] <= data_in[grant_id][e];
            end
        end
    end

    // Head of the slice drives the output, elements in their original order.
    always_comb begin
        for (int e = 0; e < UNROLL_IN_X; e++) begin
            data_out[e] = slice_mem[slice_rd_ptr][e];
        end
    end

endmodule
